fp_issue_stage: RTL and testbench
=================================

FP_ISSUE_STAGE -- requirements
Module: fp_issue_stage

Interface
REQ-001 clk_i  input  1  Single clock; all state updates on rising edge.
REQ-002 rst_ni  input  1  Reset, asynchronous, active-low.
REQ-003 instr_valid_i  input  1  Decoded FP instruction present.
REQ-004 instr_ready_o  output  1  Stage can accept the instruction this cycle.
REQ-005 fp_op_i  input  fpu_op_e  Operation, ibex_fp_pkg encoding.
REQ-006 rs1_addr_i, rs2_addr_i, rs3_addr_i, rd_addr_i  input  5 each  Register addresses.
REQ-007 rm_i  input  3  Rounding mode.
REQ-008 rs1_int_i  input  32  Integer operand for FPU_INT2FLOAT.
REQ-009 fp_op_o  output  fpu_op_e  Operation to FPU; FPU_NOP when not issuing.
REQ-010 rs1_o, rs2_o, rs3_o, rs1_int_o  output  32 each  Registered operands to FPU.
REQ-011 rd_addr_o  output  5  Destination to FPU.
REQ-012 fp_rounding_mode_o  output  3  Registered rm_i.
REQ-013 fp_wb_write_i  input  1  FPU FP-register writeback strobe.
REQ-014 fp_wb_addr_i  input  5  Writeback address.
REQ-015 fp_wb_wdata_i  input  32  Writeback data.

Function
REQ-016 Stage SHALL contain a 32x32 FP register file: two-state, one write port (writeback), three combinational read ports.
REQ-017 Stage SHALL keep a 32-bit pending scoreboard: bit set when an FP-writing op issues to its rd, cleared when fp_wb_write_i is high for that address.
REQ-018 FP-writing ops: every op except FPU_NOP and FPU_FLOAT2INT.
REQ-019 Source usage: rs1 for all ops except FPU_INT2FLOAT and FPU_NOP; rs2 for ADD, SUB, MUL, DIV, MIN, MAX, MADD, MSUB, NMADD, NMSUB; rs3 for MADD, MSUB, NMADD, NMSUB only.
REQ-020 Hazard: a used source, or rd of an FP-writing op, has its pending bit set and is not resolved by REQ-032.
REQ-021 instr_ready_o SHALL be the negation of hazard, combinational; an instruction with fp_op_i = FPU_NOP is always ready.
REQ-022 Accept = instr_valid_i & instr_ready_o; on accept, operands, rd, rm and op SHALL be registered and presented exactly 1 cycle later, for exactly 1 cycle.
REQ-023 In any cycle without a prior-cycle accept, fp_op_o SHALL be FPU_NOP; the other outputs hold their last values.
REQ-024 Writeback and issue in the same cycle to the same rd: scoreboard bit SHALL end set (issue wins).
REQ-025 Writeback to a non-pending address SHALL update the register file and leave the scoreboard unchanged.
REQ-026 Unused source fields SHALL never cause a stall.
REQ-027 Stalled instruction: no state change; it SHALL issue in the cycle its hazard clears.

Reset
REQ-028 On rst_ni low, immediately and independently of clk_i: all register file entries 0, scoreboard 0, fp_op_o FPU_NOP, operand/rd/rm outputs 0.
REQ-029 Reset asserted mid-operation SHALL discard any in-flight issue; the first accept after release behaves as after power-up.
REQ-030 instr_ready_o SHALL be 1 while in reset or idle with an empty scoreboard.

Configuration
REQ-031 Macro FP_ISSUE_BYPASS_EN selects writeback forwarding.
REQ-032 Defined: a source or rd whose pending bit is being cleared by fp_wb_write_i this cycle is not a hazard; the source reads fp_wb_wdata_i directly. Issue occurs in the writeback cycle.
REQ-033 Undefined: such a source stalls one extra cycle and reads the register file after the write. Issue occurs the cycle after writeback.

Verification
REQ-034 Reset, then x1=0x4023d70a, x2=0x41200000; ADD rs1=2, rs2=1, rd=3 -> next cycle fp_op_o=ADD, rs1_o=0x41200000, rs2_o=0x4023d70a, scoreboard[3]=1.
REQ-035 Issue MUL rd=6, then SQRT rs1=6 with writeback of 0x42c80000 two cycles later -> SQRT ready low until writeback; rs1_o=0x42c80000. Issue occurs in the writeback cycle with BYPASS_EN and one cycle later without it.
REQ-036 Pending rd=5; MADD rs3=5 -> stall; same MADD with rs3 unused (ADD rs1=2, rs2=2, rd=7) -> no stall.
REQ-037 FLOAT2INT rs1=11 then ADD rd=11 -> FLOAT2INT sets no pending bit; ADD issues with no stall.
REQ-038 Assert rst_ni low mid-stall with scoreboard[4]=1 -> same cycle fp_op_o=FPU_NOP, scoreboard 0, instr_ready_o=1; all registers read 0 after release.

Source files
------------

// File: rtl/fp_issue_stage_if.sv
// FP operation encoding shared by the issue stage and the FPU, plus the issue-stage bus bundle.
// The slave modport is the issue stage; the master modport is the decoder/FPU side that drives it.
package ibex_fp_pkg;
    typedef enum logic [3:0] {
        FPU_NOP       = 4'd0,
        FPU_ADD       = 4'd1,
        FPU_SUB       = 4'd2,
        FPU_MUL       = 4'd3,
        FPU_DIV       = 4'd4,
        FPU_SQRT      = 4'd5,
        FPU_MIN       = 4'd6,
        FPU_MAX       = 4'd7,
        FPU_MADD      = 4'd8,
        FPU_MSUB      = 4'd9,
        FPU_NMADD     = 4'd10,
        FPU_NMSUB     = 4'd11,
        FPU_FLOAT2INT = 4'd12,
        FPU_INT2FLOAT = 4'd13
    } fpu_op_e;
endpackage

interface fp_issue_stage_if;
    import ibex_fp_pkg::*;

    logic        instr_valid_i;
    logic        instr_ready_o;
    fpu_op_e     fp_op_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [4:0]  rs3_addr_i;
    logic [4:0]  rd_addr_i;
    logic [2:0]  rm_i;
    logic [31:0] rs1_int_i;

    fpu_op_e     fp_op_o;
    logic [31:0] rs1_o;
    logic [31:0] rs2_o;
    logic [31:0] rs3_o;
    logic [31:0] rs1_int_o;
    logic [4:0]  rd_addr_o;
    logic [2:0]  fp_rounding_mode_o;

    logic        fp_wb_write_i;
    logic [4:0]  fp_wb_addr_i;
    logic [31:0] fp_wb_wdata_i;

    modport slave (
        input  instr_valid_i, fp_op_i, rs1_addr_i, rs2_addr_i, rs3_addr_i, rd_addr_i,
        input  rm_i, rs1_int_i, fp_wb_write_i, fp_wb_addr_i, fp_wb_wdata_i,
        output instr_ready_o, fp_op_o, rs1_o, rs2_o, rs3_o, rs1_int_o, rd_addr_o,
        output fp_rounding_mode_o
    );

    modport master (
        output instr_valid_i, fp_op_i, rs1_addr_i, rs2_addr_i, rs3_addr_i, rd_addr_i,
        output rm_i, rs1_int_i, fp_wb_write_i, fp_wb_addr_i, fp_wb_wdata_i,
        input  instr_ready_o, fp_op_o, rs1_o, rs2_o, rs3_o, rs1_int_o, rd_addr_o,
        input  fp_rounding_mode_o
    );
endinterface

// File: rtl/fp_issue_stage.sv
// FP issue stage: 32x32 register file + pending scoreboard; accepted ops reach the FPU 1 cycle later.
// Ready drops combinationally on RAW/WAW hazards; FP_ISSUE_BYPASS_EN forwards same-cycle writeback.
module fp_issue_stage
    import ibex_fp_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    fp_issue_stage_if.slave fp_if
);

`ifdef FP_ISSUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [31:0] r_rf [32];
    logic [31:0] r_sb;
    fpu_op_e     r_fp_op;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [31:0] r_rs3;
    logic [31:0] r_rs1_int;
    logic [4:0]  r_rd;
    logic [2:0]  r_rm;

    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_use_rs3;
    logic        w_wr_fp;
    logic [31:0] w_wb_mask;
    logic [31:0] w_busy;
    logic        w_hazard;
    logic        w_accept;
    logic [31:0] w_sb_set;
    logic        w_fwd_rs1;
    logic        w_fwd_rs2;
    logic        w_fwd_rs3;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_rs3_val;

    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rs3 = 1'b0;
        w_wr_fp   = 1'b0;
        case (fp_if.fp_op_i)
            FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV, FPU_MIN, FPU_MAX: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_wr_fp   = 1'b1;
            end
            FPU_MADD, FPU_MSUB, FPU_NMADD, FPU_NMSUB: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_rs3 = 1'b1;
                w_wr_fp   = 1'b1;
            end
            FPU_SQRT: begin
                w_use_rs1 = 1'b1;
                w_wr_fp   = 1'b1;
            end
            FPU_FLOAT2INT: w_use_rs1 = 1'b1;
            FPU_INT2FLOAT: w_wr_fp   = 1'b1;
            default: ;
        endcase
    end

    // With forwarding, a bit being cleared by this cycle's writeback no longer blocks issue.
    assign w_wb_mask = fp_if.fp_wb_write_i ? (32'h1 << fp_if.fp_wb_addr_i) : 32'h0;
    assign w_busy    = BYPASS ? (r_sb & ~w_wb_mask) : r_sb;

    assign w_hazard  = (w_use_rs1 & w_busy[fp_if.rs1_addr_i])
                     | (w_use_rs2 & w_busy[fp_if.rs2_addr_i])
                     | (w_use_rs3 & w_busy[fp_if.rs3_addr_i])
                     | (w_wr_fp   & w_busy[fp_if.rd_addr_i]);

    assign fp_if.instr_ready_o = ~w_hazard;
    assign w_accept            = fp_if.instr_valid_i & ~w_hazard;
    assign w_sb_set            = (w_accept & w_wr_fp) ? (32'h1 << fp_if.rd_addr_i) : 32'h0;

    assign w_fwd_rs1 = BYPASS && fp_if.fp_wb_write_i && (fp_if.fp_wb_addr_i == fp_if.rs1_addr_i);
    assign w_fwd_rs2 = BYPASS && fp_if.fp_wb_write_i && (fp_if.fp_wb_addr_i == fp_if.rs2_addr_i);
    assign w_fwd_rs3 = BYPASS && fp_if.fp_wb_write_i && (fp_if.fp_wb_addr_i == fp_if.rs3_addr_i);

    assign w_rs1_val = w_fwd_rs1 ? fp_if.fp_wb_wdata_i : r_rf[fp_if.rs1_addr_i];
    assign w_rs2_val = w_fwd_rs2 ? fp_if.fp_wb_wdata_i : r_rf[fp_if.rs2_addr_i];
    assign w_rs3_val = w_fwd_rs3 ? fp_if.fp_wb_wdata_i : r_rf[fp_if.rs3_addr_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 32'h0;
            end
        end else if (fp_if.fp_wb_write_i) begin
            r_rf[fp_if.fp_wb_addr_i] <= fp_if.fp_wb_wdata_i;
        end
    end

    // Set after clear so an issue to the register being written back stays pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sb <= 32'h0;
        end else begin
            r_sb <= (r_sb & ~w_wb_mask) | w_sb_set;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fp_op   <= FPU_NOP;
            r_rs1     <= 32'h0;
            r_rs2     <= 32'h0;
            r_rs3     <= 32'h0;
            r_rs1_int <= 32'h0;
            r_rd      <= 5'h0;
            r_rm      <= 3'h0;
        end else if (w_accept) begin
            r_fp_op   <= fp_if.fp_op_i;
            r_rs1     <= w_rs1_val;
            r_rs2     <= w_rs2_val;
            r_rs3     <= w_rs3_val;
            r_rs1_int <= fp_if.rs1_int_i;
            r_rd      <= fp_if.rd_addr_i;
            r_rm      <= fp_if.rm_i;
        end else begin
            r_fp_op   <= FPU_NOP;
        end
    end

    assign fp_if.fp_op_o            = r_fp_op;
    assign fp_if.rs1_o              = r_rs1;
    assign fp_if.rs2_o              = r_rs2;
    assign fp_if.rs3_o              = r_rs3;
    assign fp_if.rs1_int_o          = r_rs1_int;
    assign fp_if.rd_addr_o          = r_rd;
    assign fp_if.fp_rounding_mode_o = r_rm;

endmodule

// File: tb/tb_fp_issue_stage.sv
// Bench for fp_issue_stage: ready-decode vector table, directed hazard/reset sequences, random run vs model.
module tb_fp_issue_stage;
    import ibex_fp_pkg::*;

`ifdef FP_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_issue_stage_if bus();
    fp_issue_stage dut (.clk_i(clk), .rst_ni(rst_n), .fp_if(bus));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        fpu_op_e    op;
        logic [4:0] rs1, rs2, rs3, rd;
        logic       exp_rdy;
    } vec_t;
    vec_t tbl[13];

    logic [31:0] m_rf [32];
    bit          m_pend [32];
    fpu_op_e     m_op;
    logic [31:0] m_rs1, m_rs2, m_rs3, m_int;
    logic [4:0]  m_rd;
    logic [2:0]  m_rm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_instr(input logic v, input fpu_op_e op, input logic [4:0] a1,
                             input logic [4:0] a2, input logic [4:0] a3, input logic [4:0] d);
        bus.instr_valid_i = v;
        bus.fp_op_i       = op;
        bus.rs1_addr_i    = a1;
        bus.rs2_addr_i    = a2;
        bus.rs3_addr_i    = a3;
        bus.rd_addr_i     = d;
    endtask

    task automatic set_wb(input logic w, input logic [4:0] a, input logic [31:0] d);
        bus.fp_wb_write_i = w;
        bus.fp_wb_addr_i  = a;
        bus.fp_wb_wdata_i = d;
    endtask

    task automatic idle();
        set_instr(1'b0, FPU_NOP, 5'd0, 5'd0, 5'd0, 5'd0);
        set_wb(1'b0, 5'd0, 32'h0);
        bus.rm_i      = 3'd0;
        bus.rs1_int_i = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operand classes straight from the op definitions: 0=rs1, 1=rs2, 2=rs3, 3=rd written.
    function automatic bit uses(input fpu_op_e op, input int role);
        case (role)
            0: return !(op inside {FPU_NOP, FPU_INT2FLOAT});
            1: return op inside {FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV, FPU_MIN, FPU_MAX,
                                 FPU_MADD, FPU_MSUB, FPU_NMADD, FPU_NMSUB};
            2: return op inside {FPU_MADD, FPU_MSUB, FPU_NMADD, FPU_NMSUB};
            default: return !(op inside {FPU_NOP, FPU_FLOAT2INT});
        endcase
    endfunction

    function automatic bit model_hazard(input fpu_op_e op, input int a1, input int a2,
                                        input int a3, input int d, input bit wbv, input int wba);
        int a[4];
        a[0] = a1; a[1] = a2; a[2] = a3; a[3] = d;
        for (int k = 0; k < 4; k++) begin
            if (uses(op, k) && m_pend[a[k]] && !(BYP && wbv && wba == a[k])) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input int a, input bit wbv, input int wba,
                                               input logic [31:0] wbd);
        if (BYP && wbv && wba == a) return wbd;
        return m_rf[a];
    endfunction

    initial begin
        tbl[0]  = '{FPU_MADD,      5'd1, 5'd2, 5'd5, 5'd9,  1'b0};
        tbl[1]  = '{FPU_ADD,       5'd2, 5'd2, 5'd5, 5'd7,  1'b1};
        tbl[2]  = '{FPU_SQRT,      5'd1, 5'd5, 5'd5, 5'd8,  1'b1};
        tbl[3]  = '{FPU_SQRT,      5'd5, 5'd1, 5'd1, 5'd8,  1'b0};
        tbl[4]  = '{FPU_INT2FLOAT, 5'd5, 5'd5, 5'd5, 5'd8,  1'b1};
        tbl[5]  = '{FPU_INT2FLOAT, 5'd1, 5'd1, 5'd1, 5'd5,  1'b0};
        tbl[6]  = '{FPU_FLOAT2INT, 5'd1, 5'd5, 5'd5, 5'd5,  1'b1};
        tbl[7]  = '{FPU_FLOAT2INT, 5'd5, 5'd1, 5'd1, 5'd8,  1'b0};
        tbl[8]  = '{FPU_NOP,       5'd5, 5'd5, 5'd5, 5'd5,  1'b1};
        tbl[9]  = '{FPU_MIN,       5'd1, 5'd5, 5'd1, 5'd8,  1'b0};
        tbl[10] = '{FPU_DIV,       5'd1, 5'd5, 5'd1, 5'd8,  1'b0};
        tbl[11] = '{FPU_NMSUB,     5'd1, 5'd2, 5'd5, 5'd8,  1'b0};
        tbl[12] = '{FPU_MAX,       5'd1, 5'd2, 5'd5, 5'd3,  1'b1};

        idle();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #14;
        chk("reset fp_op_o", bus.fp_op_o, FPU_NOP);
        chk("reset ready", bus.instr_ready_o, 1'b1);
        chk("reset rs1_o", bus.rs1_o, 32'h0);
        chk("reset rd_addr_o", bus.rd_addr_o, 5'd0);
        chk("reset rm_o", bus.fp_rounding_mode_o, 3'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Basic ADD after loading x1/x2 through writeback to non-pending registers.
        set_wb(1'b1, 5'd1, 32'h4023d70a); tick();
        set_wb(1'b1, 5'd2, 32'h41200000); tick();
        set_wb(1'b0, 5'd0, 32'h0);
        set_instr(1'b1, FPU_ADD, 5'd2, 5'd1, 5'd0, 5'd3);
        @(negedge clk); chk("add ready", bus.instr_ready_o, 1'b1);
        tick();
        set_instr(1'b0, FPU_SQRT, 5'd3, 5'd0, 5'd0, 5'd9);
        chk("add fp_op_o", bus.fp_op_o, FPU_ADD);
        chk("add rs1_o", bus.rs1_o, 32'h41200000);
        chk("add rs2_o", bus.rs2_o, 32'h4023d70a);
        chk("add rd_addr_o", bus.rd_addr_o, 5'd3);
        @(negedge clk); chk("x3 pending", bus.instr_ready_o, 1'b0);
        tick();
        chk("issue lasts one cycle", bus.fp_op_o, FPU_NOP);
        chk("hold rs1_o", bus.rs1_o, 32'h41200000);
        idle(); set_wb(1'b1, 5'd3, 32'h3f800000); tick(); idle();

        for (int i = 0; i < 13; i++) begin
            set_instr(1'b1, FPU_INT2FLOAT, 5'd0, 5'd0, 5'd0, 5'd5);
            tick();
            set_instr(1'b0, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rs3, tbl[i].rd);
            @(negedge clk);
            chk($sformatf("vec%0d ready", i), bus.instr_ready_o, tbl[i].exp_rdy);
            tick();
            idle(); set_wb(1'b1, 5'd5, 32'h0); tick(); idle();
        end

        // MUL rd=6 then dependent SQRT; writeback arrives two cycles after the MUL issues.
        set_instr(1'b1, FPU_MUL, 5'd1, 5'd2, 5'd0, 5'd6); tick();
        set_instr(1'b1, FPU_SQRT, 5'd6, 5'd0, 5'd0, 5'd10);
        @(negedge clk); chk("sqrt stall", bus.instr_ready_o, 1'b0);
        tick();
        chk("stall gives nop", bus.fp_op_o, FPU_NOP);
        set_wb(1'b1, 5'd6, 32'h42c80000);
        @(negedge clk); chk("sqrt ready in wb cycle", bus.instr_ready_o, BYP);
        tick();
        set_wb(1'b0, 5'd0, 32'h0);
        if (!BYP) begin
            chk("sqrt held", bus.fp_op_o, FPU_NOP);
            @(negedge clk); chk("sqrt ready after wb", bus.instr_ready_o, 1'b1);
            tick();
        end
        idle();
        chk("sqrt fp_op_o", bus.fp_op_o, FPU_SQRT);
        chk("sqrt rs1_o", bus.rs1_o, 32'h42c80000);
        set_wb(1'b1, 5'd10, 32'h0); tick(); idle();

        // FLOAT2INT must not mark its rd pending.
        set_instr(1'b1, FPU_FLOAT2INT, 5'd11, 5'd0, 5'd0, 5'd11); tick();
        chk("f2i fp_op_o", bus.fp_op_o, FPU_FLOAT2INT);
        set_instr(1'b1, FPU_ADD, 5'd1, 5'd2, 5'd0, 5'd11);
        @(negedge clk); chk("add after f2i ready", bus.instr_ready_o, 1'b1);
        tick(); idle();
        chk("add after f2i op", bus.fp_op_o, FPU_ADD);
        set_wb(1'b1, 5'd11, 32'h0); tick(); idle();

        // Issue and writeback to the same rd in one cycle: pending must survive.
        set_instr(1'b1, FPU_ADD, 5'd1, 5'd2, 5'd0, 5'd12);
        set_wb(1'b1, 5'd12, 32'h11111111);
        @(negedge clk); chk("same-cycle issue ready", bus.instr_ready_o, 1'b1);
        tick(); idle();
        set_instr(1'b0, FPU_SQRT, 5'd12, 5'd0, 5'd0, 5'd13);
        @(negedge clk); chk("issue wins over wb", bus.instr_ready_o, 1'b0);
        tick();
        set_wb(1'b1, 5'd12, 32'h0); tick(); set_wb(1'b0, 5'd0, 32'h0);
        @(negedge clk); chk("wb clears pending", bus.instr_ready_o, 1'b1);
        tick(); idle();

        // Writeback to a non-pending register updates data only.
        set_wb(1'b1, 5'd20, 32'hdeadbeef); tick(); set_wb(1'b0, 5'd0, 32'h0);
        set_instr(1'b1, FPU_ADD, 5'd20, 5'd20, 5'd0, 5'd21);
        @(negedge clk); chk("wb non-pending ready", bus.instr_ready_o, 1'b1);
        tick(); idle();
        chk("wb non-pending data", bus.rs1_o, 32'hdeadbeef);
        set_wb(1'b1, 5'd21, 32'h0); tick(); idle();

        // Reset in the middle of a stall.
        set_instr(1'b1, FPU_INT2FLOAT, 5'd0, 5'd0, 5'd0, 5'd4);
        bus.rs1_int_i = 32'h00001234;
        tick();
        chk("i2f fp_op_o", bus.fp_op_o, FPU_INT2FLOAT);
        set_instr(1'b1, FPU_SQRT, 5'd4, 5'd0, 5'd0, 5'd14);
        #1 chk("stall before reset", bus.instr_ready_o, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset fp_op_o", bus.fp_op_o, FPU_NOP);
        chk("async reset ready", bus.instr_ready_o, 1'b1);
        chk("async reset rs1_int_o", bus.rs1_int_o, 32'h0);
        chk("async reset rd_addr_o", bus.rd_addr_o, 5'd0);
        @(negedge clk) rst_n = 1'b1;
        idle(); tick();
        set_instr(1'b1, FPU_MADD, 5'd1, 5'd2, 5'd20, 5'd22);
        @(negedge clk); chk("post-reset ready", bus.instr_ready_o, 1'b1);
        tick(); idle();
        chk("post-reset op", bus.fp_op_o, FPU_MADD);
        chk("post-reset x1", bus.rs1_o, 32'h0);
        chk("post-reset x2", bus.rs2_o, 32'h0);
        chk("post-reset x20", bus.rs3_o, 32'h0);

        // Random run against the model, starting from a fresh reset.
        @(negedge clk) rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = 32'h0;
            m_pend[i] = 1'b0;
        end
        m_op = FPU_NOP; m_rs1 = 0; m_rs2 = 0; m_rs3 = 0; m_int = 0; m_rd = 0; m_rm = 0;
        tick();
        for (int n = 0; n < 3000; n++) begin
            fpu_op_e     op;
            int          a1, a2, a3, d, wba;
            bit          v, wbv, hz, acc;
            logic [31:0] wbd, e1, e2, e3, ei;
            logic [2:0]  rm;
            int          q[$];
            op  = fpu_op_e'(4'($urandom_range(0, 13)));
            a1  = $urandom_range(0, 7);
            a2  = $urandom_range(0, 7);
            a3  = $urandom_range(0, 7);
            d   = $urandom_range(0, 7);
            v   = ($urandom_range(0, 3) != 0);
            rm  = 3'($urandom_range(0, 7));
            ei  = $urandom;
            wbd = $urandom;
            wbv = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < 32; k++) if (m_pend[k]) q.push_back(k);
            if (q.size() > 0 && $urandom_range(0, 3) != 0) wba = q[$urandom_range(0, q.size() - 1)];
            else wba = $urandom_range(0, 31);
            set_instr(v, op, 5'(a1), 5'(a2), 5'(a3), 5'(d));
            bus.rm_i = rm;
            bus.rs1_int_i = ei;
            set_wb(wbv, 5'(wba), wbd);
            hz  = model_hazard(op, a1, a2, a3, d, wbv, wba);
            acc = v && !hz;
            e1  = model_read(a1, wbv, wba, wbd);
            e2  = model_read(a2, wbv, wba, wbd);
            e3  = model_read(a3, wbv, wba, wbd);
            @(negedge clk);
            chk($sformatf("rnd%0d ready", n), bus.instr_ready_o, !hz);
            tick();
            if (acc) begin
                m_op = op; m_rs1 = e1; m_rs2 = e2; m_rs3 = e3;
                m_int = ei; m_rd = 5'(d); m_rm = rm;
            end else begin
                m_op = FPU_NOP;
            end
            if (wbv) begin
                m_rf[wba]   = wbd;
                m_pend[wba] = 1'b0;
            end
            if (acc && uses(op, 3)) m_pend[d] = 1'b1;
            chk($sformatf("rnd%0d fp_op_o", n), bus.fp_op_o, m_op);
            chk($sformatf("rnd%0d rs1_o", n), bus.rs1_o, m_rs1);
            chk($sformatf("rnd%0d rs2_o", n), bus.rs2_o, m_rs2);
            chk($sformatf("rnd%0d rs3_o", n), bus.rs3_o, m_rs3);
            chk($sformatf("rnd%0d rs1_int_o", n), bus.rs1_int_o, m_int);
            chk($sformatf("rnd%0d rd_addr_o", n), bus.rd_addr_o, m_rd);
            chk($sformatf("rnd%0d rm_o", n), bus.fp_rounding_mode_o, m_rm);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
